mem_arbiter: RTL
================

# mem_arbiter

Shares the single main-memory port between the instruction-cache and data-cache miss paths, and turns each granted miss into a full block-refill burst. It sits between the two caches' memory-transaction ports (request/address in; valid/last/data back) and one synchronous word-addressed RAM with a 1-cycle read latency. Arbitration is two-way round-robin, decided once per burst. A burst is never interrupted.

## Interface
Parameters:
- DATA_WIDTH, 32, memory word width
- ADDR_WIDTH, 20, word address width of main memory
- BLOCK_OFFSET_WIDTH, 9, log2 of words per cache block; burst length N = 2^BLOCK_OFFSET_WIDTH

Ports:
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- i_req  input  1  instruction-cache miss request, level, held until i_last seen
- i_addr  input  ADDR_WIDTH  instruction miss address; offset bits ignored
- i_valid  output  1  word for instruction cache valid this cycle
- i_last  output  1  final word of instruction burst
- i_data  output  DATA_WIDTH  refill word
- d_req / d_addr / d_valid / d_last / d_data  same as i_*, data-cache side
- ram_en  output  1  RAM read enable
- ram_addr  output  ADDR_WIDTH  RAM read address
- ram_rdata  input  DATA_WIDTH  RAM data, valid the cycle after ram_en
- busy  output  1  state != IDLE
- grant  output  1  owner of current/last burst: 0 = instruction, 1 = data

## Operation
- States: IDLE, BURST, DRAIN.
- IDLE:
  - If any request is high, select the owner, then go to BURST.
  - Latch owner into grant.
  - Latch base = req_addr[ADDR_WIDTH-1:BLOCK_OFFSET_WIDTH].
  - Clear the issue counter cnt.
- Round-robin:
  - Only one request high: that requester wins.
  - Both high: the requester not served by the previous burst wins.
  - last_served resets to 1 (data), so the first tie after reset goes to instruction.
- BURST:
  - ram_en=1, ram_addr={base, cnt}; cnt increments each cycle.
  - Address never leaves the block, so there is no carry into base.
  - When cnt == N-1 is issued, go to DRAIN.
- Return pipeline: registered rv (= ram_en delayed 1) and ridx (= cnt delayed 1).
  - Owner's valid = rv, data = ram_rdata, last = rv && ridx == N-1.
  - The non-owner's valid and last are 0.
  - Both data outputs are 0 whenever their valid is 0.
- DRAIN:
  - Final word returns with last=1.
  - Update last_served=grant, then go to IDLE.
- Requests are sampled only in IDLE.
  - A request dropping mid-burst does not abort; the burst completes.
  - A request rising during another's burst waits.
- No valid/last is ever asserted to both caches in the same cycle.

## Timing
- Reset (asynchronous, immediate) forces:
  - state=IDLE, cnt=0, rv=0, ridx=0, last_served=1, grant=0.
  - All outputs 0: ram_en, ram_addr, i_valid/i_last/i_data, d_valid/d_last/d_data, busy.
- Reset mid-burst abandons the burst with no further valid; the caches are reset by the same rst_n.
- Request sampled in IDLE at cycle t:
  - ram_en cycles t+1..t+N.
  - valid cycles t+2..t+N+1, last at t+N+1 (DRAIN).
  - IDLE again at t+N+2.
- Latency from request to first word is 2 cycles; one burst occupies N+2 cycles including the IDLE cycle.
- Valid is continuous for the whole burst (no bubbles); the caches never stall.
- A cache drops its req the cycle after last, so the IDLE cycle at t+N+2 never re-grants a finished miss.
- A waiting requester is granted in that IDLE cycle: back-to-back bursts have a 2-cycle valid gap.
- busy is high t+1..t+N+1.

## Test plan
With BLOCK_OFFSET_WIDTH=2 (N=4), ADDR_WIDTH=20:
- Single instruction miss: i_req=1, i_addr=0x00405 sampled at cycle 0.
  - ram_addr 0x00404..0x00407 at cycles 1-4.
  - i_valid at cycles 2-5 with RAM contents in order; i_last only at cycle 5.
  - d_valid stays 0; busy 1-5.
- Simultaneous requests after reset: i_req and d_req both high at cycle 0.
  - Instruction burst first (valid 2-5).
  - Data granted at cycle 6, d_valid 8-11, grant=1.
  - Repeating the tie afterwards grants instruction again.
- Late arrival: d_req rises at cycle 3 during an instruction burst.
  - No d_valid before cycle 8; data burst uses d_addr base with offset 0.
- Request drop: i_req falls at cycle 2.
  - Burst still completes through cycle 5 with i_last.
  - No new grant at cycle 6.
- Reset mid-burst: rst_n low at cycle 3.
  - All outputs 0 immediately; state IDLE.
  - After release, a fresh i_req restarts at word offset 0.
- Maximum address: i_addr=0xFFFFF gives ram_addr 0xFFFFC..0xFFFFF, no wrap into other blocks.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of one RAM read port between I- and D-cache
// block refills; each grant becomes an uninterrupted N-word burst.
module mem_arbiter #(
  parameter int DATA_WIDTH         = 32,
  parameter int ADDR_WIDTH         = 20,
  parameter int BLOCK_OFFSET_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_valid,
  output logic                  i_last,
  output logic [DATA_WIDTH-1:0] i_data,
  input  logic                  d_req,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  output logic                  d_valid,
  output logic                  d_last,
  output logic [DATA_WIDTH-1:0] d_data,
  output logic                  ram_en,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  busy,
  output logic                  grant
);
  localparam int BW = BLOCK_OFFSET_WIDTH;
  typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;
  state_t                 r_state;
  logic [BW-1:0]          r_cnt, r_ridx;
  logic [ADDR_WIDTH-BW-1:0] r_base;
  logic                   r_rv, r_last_served, r_grant;
  logic                   w_owner, w_last;
  logic                   w_unused;
  // on a tie, favour whoever did not own the previous burst
  assign w_owner  = (i_req && d_req) ? ~r_last_served : d_req;
  assign w_unused = ^{i_addr[BW-1:0], d_addr[BW-1:0]};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_ridx        <= '0;
      r_base        <= '0;
      r_rv          <= 1'b0;
      r_last_served <= 1'b1;
      r_grant       <= 1'b0;
    end else begin
      r_rv   <= r_state == BURST;
      r_ridx <= r_cnt;
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (i_req || d_req) begin
            r_state <= BURST;
            r_grant <= w_owner;
            r_base  <= w_owner ? d_addr[ADDR_WIDTH-1:BW] : i_addr[ADDR_WIDTH-1:BW];
          end
        end
        BURST: begin
          r_cnt <= r_cnt + 1'b1;
          if (&r_cnt) r_state <= DRAIN;
        end
        DRAIN: begin
          r_state       <= IDLE;
          r_last_served <= r_grant;
        end
        default: r_state <= IDLE;
      endcase
    end
  assign ram_en   = r_state == BURST;
  assign ram_addr = ram_en ? {r_base, r_cnt} : '0;
  assign busy     = r_state != IDLE;
  assign grant    = r_grant;
  assign w_last   = r_rv && (&r_ridx);
  assign i_valid  = r_rv && !r_grant;
  assign d_valid  = r_rv && r_grant;
  assign i_last   = w_last && !r_grant;
  assign d_last   = w_last && r_grant;
  assign i_data   = i_valid ? ram_rdata : '0;
  assign d_data   = d_valid ? ram_rdata : '0;
endmodule
